// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle between producer, subtractor and consumer.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start_valid, a, b, done_ready,
        input  start_ready, done_valid, diff, borrow_out, overflow
    );

    modport slave (
        input  start_valid, a, b, done_ready,
        output start_ready, done_valid, diff, borrow_out, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = a - b - Bin, Bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = a ^ b ^ Bin;
    assign Bout = (~a & b) | (~a & Bin) | (b & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, r_q, r_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             cell_d, cell_bout;
    logic             is_run, is_done, last_bit;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .Bin  (bin_q),
        .D    (cell_d),
        .Bout (cell_bout)
    );

    assign is_run   = (state_q == ST_RUN);
    assign is_done  = (state_q == ST_DONE);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // The unused encoding 2'd3 behaves exactly like IDLE.
    assign bus.start_ready = ~is_run & ~is_done;
    assign bus.done_valid  = is_done;
    assign bus.diff        = diff_q;
    assign bus.borrow_out  = borrow_q;
    assign bus.overflow    = ovf_q;

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        case (state_q)
            ST_RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                r_d   = {cell_d, r_q[WIDTH-1:1]};
                bin_d = cell_bout;
                if (last_bit) begin
                    // Hold the counter on the final bit so it never wraps.
                    state_d  = ST_DONE;
                    diff_d   = {cell_d, r_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
                    ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.done_ready) state_d = ST_IDLE;
            end
            default: begin
                if (bus.start_valid) begin
                    state_d = ST_RUN;
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int n;
        n = 0;
        while (!bus.start_ready && n < 50) begin
            tick();
            n++;
        end
        bus.a           = ia;
        bus.b           = ib;
        bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack();
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic [W-1:0] ed, input logic ebo, input logic eov);
        int lat;
        start_op(ia, ib);
        wait_done(lat);
        chk({tag, "_lat"}, lat, W);
        chk({tag, "_diff"}, bus.diff, ed);
        chk({tag, "_bo"}, bus.borrow_out, ebo);
        chk({tag, "_ov"}, bus.overflow, eov);
        ack();
        chk({tag, "_rdy"}, bus.start_ready, 1'b1);
    endtask

    initial begin
        int             lat;
        logic [W-1:0]   ra, rb, md;
        logic [W:0]     wide;
        logic           mov;

        n_tests         = 0;
        n_fail          = 0;
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        rst_n           = 1'b0;
        #12;
        chk("rst_start_ready", bus.start_ready, 1'b1);
        chk("rst_done_valid", bus.done_valid, 1'b0);
        chk("rst_diff", bus.diff, 8'h00);
        chk("rst_flags", {bus.borrow_out, bus.overflow}, 2'b00);
        rst_n = 1'b1;
        tick();

        run_vec("v200_55", 8'd200, 8'd55, 8'd145, 1'b0, 1'b0);
        run_vec("v5_9", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
        run_vec("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_vec("va5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
        run_vec("v00_ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

        // Backpressure in DONE with start_valid pulses that must be ignored.
        start_op(8'd5, 8'd9);
        wait_done(lat);
        chk("bp_lat", lat, W);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = (i % 2 == 0);
            bus.a           = 8'h33;
            bus.b           = 8'h11;
            tick();
            chk("bp_diff", bus.diff, 8'hFC);
            chk("bp_flags", {bus.borrow_out, bus.overflow}, 2'b10);
            chk("bp_start_ready", bus.start_ready, 1'b0);
            chk("bp_done_valid", bus.done_valid, 1'b1);
        end
        bus.start_valid = 1'b0;
        ack();
        chk("bp_idle_rdy", bus.start_ready, 1'b1);
        chk("bp_idle_diff", bus.diff, 8'hFC);
        chk("bp_idle_bo", bus.borrow_out, 1'b1);

        // Reset during RUN cycle 3 aborts the operation.
        start_op(8'h40, 8'h03);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", bus.diff, 8'h00);
        chk("mid_rst_flags", {bus.borrow_out, bus.overflow}, 2'b00);
        chk("mid_rst_start_ready", bus.start_ready, 1'b1);
        chk("mid_rst_done_valid", bus.done_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            chk("mid_rst_no_done", bus.done_valid, 1'b0);
        end
        run_vec("post_rst", 8'd1, 8'd2, 8'hFF, 1'b1, 1'b0);

        // Back-to-back: start_valid held high across the done handshake.
        bus.a           = 8'h7F;
        bus.b           = 8'hFF;
        bus.start_valid = 1'b1;
        tick();
        bus.a = 8'h10;
        bus.b = 8'h20;
        wait_done(lat);
        chk("b2b_lat1", lat, W);
        chk("b2b_diff1", bus.diff, 8'h80);
        chk("b2b_flags1", {bus.borrow_out, bus.overflow}, 2'b11);
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        chk("b2b_k_rdy", bus.start_ready, 1'b1);
        chk("b2b_k_dv", bus.done_valid, 1'b0);
        tick();
        chk("b2b_k1_accept", bus.start_ready, 1'b0);
        bus.start_valid = 1'b0;
        wait_done(lat);
        chk("b2b_lat2", lat, W);
        chk("b2b_diff2", bus.diff, 8'hF0);
        chk("b2b_flags2", {bus.borrow_out, bus.overflow}, 2'b10);
        ack();

        for (int i = 0; i < 100; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            wide = {1'b0, ra} - {1'b0, rb};
            md   = wide[W-1:0];
            mov  = (ra[W-1] != rb[W-1]) && (md[W-1] != ra[W-1]);
            start_op(ra, rb);
            wait_done(lat);
            chk("rnd_lat", lat, W);
            chk("rnd_diff", bus.diff, md);
            chk("rnd_bo", bus.borrow_out, wide[W]);
            chk("rnd_ov", bus.overflow, mov);
            ack();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor that computes `diff = a - b` one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow. It is the arithmetic counterpart of the team's full-adder datapath. Area-constrained paths use it when a parallel subtract is not affordable. Operands enter and results leave through valid/ready handshakes, so it drops between a producer and consumer without glue logic.

## Interface
- `WIDTH`, default 8: operand and result width; legal range ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start_valid` in 1: producer presents the operands `a` and `b`.
- `start_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend; sampled only on the start handshake.
- `b` in WIDTH: subtrahend; sampled only on the start handshake.
- `done_valid` out 1: result outputs are valid.
- `done_ready` in 1: consumer accepts the result.
- `diff` out WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out` out 1: unsigned borrow; 1 iff `a < b` unsigned.
- `overflow` out 1: signed two's-complement overflow of `a - b`.

## Operation
- FSM states and transitions:
  - IDLE: accepts operands. On `start_valid && start_ready`, goes to RUN.
  - RUN: performs the subtraction, one bit per cycle, for exactly WIDTH cycles, then goes to DONE.
  - DONE: holds the result. On `done_valid && done_ready`, returns to IDLE.
- `start_ready = (state == IDLE)` and `done_valid = (state == DONE)`. Both are decoded combinationally from the state register.
- On the start handshake edge:
  - `a` loads into shift register SA and `b` loads into shift register SB.
  - The borrow register clears to 0.
  - The bit counter clears to 0.
- On each RUN edge:
  - The cell computes `d = SA[0] ^ SB[0] ^ bin` and `bout = (~SA[0] & SB[0]) | (~SA[0] & bin) | (SB[0] & bin)`.
  - SA and SB shift right by one.
  - `d` shifts into the MSB of result register R, and R shifts right.
  - The borrow register takes `bout`.
  - The counter increments.
- On the RUN edge where counter == WIDTH-1, the FSM moves to DONE. At that same edge:
  - `borrow_out` is set to the final `bout`.
  - `overflow` is set to `(a[MSB] != b[MSB]) && (d != a[MSB])`, where `d` is the final difference bit. The original MSB of `a` and of `b` are captured at the start handshake.
- `diff` is driven from R.
- `diff`, `borrow_out` and `overflow` are held stable from DONE entry until the done handshake, and remain unchanged in IDLE until the next DONE entry.
- `start_valid` is ignored outside IDLE. `a` and `b` may change freely after the start handshake.
- `done_ready` is ignored outside DONE.

## Timing
- Reset, asynchronous assertion:
  - state = IDLE, so `start_ready` = 1 and `done_valid` = 0.
  - `diff`, `borrow_out`, `overflow`, SA, SB, R, borrow register and counter = 0.
- Reset asserted mid-RUN or in DONE aborts the operation. The result is lost and no `done_valid` pulse occurs.
- Latency: start handshake on edge 0, then `done_valid` is high after edge WIDTH (e.g. 8 cycles for WIDTH=8).
- Done handshake on edge k: `start_ready` is high after edge k, so the earliest next start handshake is edge k+1.
- Initiation interval: WIDTH + 2 cycles minimum (start edge, WIDTH RUN edges, done edge).
- With `done_ready` already high on DONE entry, DONE lasts exactly one cycle.
- No combinational path from `start_valid` or `done_ready` to any output.
- Counter width: `$clog2(WIDTH)` bits; it never wraps within an operation.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a counter-width function/constant. 2'd3 is unreachable and decodes to IDLE.
- Sub-module `full_subtractor`: ports `a`, `b`, `Bin` in; `D`, `Bout` out. Purely combinational, instantiated once. It is the borrow-chain dual of the full adder.
- Top level contains only the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, a=200, b=55 -> `diff`=145, `borrow_out`=0, `overflow`=0; `done_valid` high 8 cycles after the start handshake.
- a=5, b=9 -> `diff`=0xFC, `borrow_out`=1, `overflow`=0.
- a=0x80, b=0x01 -> `diff`=0x7F, `borrow_out`=0, `overflow`=1. a=0xA5, b=0xA5 -> `diff`=0, `borrow_out`=0, `overflow`=0.
- Backpressure: hold `done_ready`=0 for 5 cycles in DONE while pulsing `start_valid` with other operands. Required response:
  - `diff`, `borrow_out` and `overflow` stay constant.
  - `start_ready` stays 0.
  - The pulsed operands are not captured.
- Reset mid-op: assert `rst_n`=0 at RUN cycle 3. Required response:
  - All outputs go to 0 immediately and `start_ready`=1.
  - After release, a=1, b=2 -> `diff`=0xFF, `borrow_out`=1.
- Back-to-back: done handshake at edge k, `start_valid` held high. Required response:
  - Next operands are accepted at edge k+1.
  - Second result is valid after edge k+1+WIDTH.
  - 100 random operand pairs all match the reference model `a - b`.
